tex_column_seq: RTL and testbench
=================================

TEX_COLUMN_SEQ -- requirements
Module: tex_column_seq

Interface
REQ-001 SHALL have parameters: SCREEN_WIDTH, default 320, columns; SCREEN_HEIGHT, default 180, rows; CEIL_COLOR, default 16'h39E7, RGB565 ceiling; FLOOR_COLOR, default 16'h7BEF, RGB565 floor; FLAT_COLOR, default 16'hF800, RGB565 for untextured wall codes.
REQ-002 SHALL have ports, one clock, asynchronous active-high reset:
- pixel_clk_in in 1: clock.
- rst_in in 1: async reset, active-high.
- dda_valid_in in 1: column descriptor valid.
- dda_ready_out out 1: ready for a descriptor.
- hcount_ray_in in 9: column index.
- lineheight_in in 8: wall height.
- drawstart_in in 10: first wall row, signed.
- drawend_in in 10: last wall row, signed.
- wallX_in in 16: hit fraction.
- texture_in in 4: map code.
- side_in in 1: side hit.
- tex_req_out out 1: texture request pulse.
- wallX_out, lineheight_out, drawstart_out, texture_out out 16/8/10/4: latched operands.
- vcount_ray_out out 8: current row.
- tex_pixel_in in 16: texel.
- tex_valid_in in 1: texel valid.
- fb_we_out out 1: framebuffer write.
- fb_addr_out out 16: write address.
- fb_data_out out 16: RGB565 pixel.
- column_done_out out 1: column complete pulse.

Function
REQ-003 SHALL accept a descriptor on the rising edge where dda_valid_in && dda_ready_out, latching all descriptor inputs.
REQ-004 dda_ready_out SHALL be high only in IDLE.
REQ-005 States SHALL be IDLE, ROW, REQ, WAIT and DONE:
- IDLE -> ROW on accept.
- ROW: non-wall row -> write, stay in ROW; wall row with textured code -> REQ.
- REQ -> WAIT after one cycle.
- WAIT -> ROW on tex_valid_in, writing the pixel and advancing the row.
- ROW -> DONE after row SCREEN_HEIGHT-1 is written.
- DONE -> IDLE after one cycle.
REQ-006 Drawstart and drawend SHALL be clamped to 0..SCREEN_HEIGHT-1 at latch; wall rows are clamped drawstart <= row <= clamped drawend.
REQ-007 If drawend < drawstart after clamping, or texture_in == 0, the column SHALL contain no wall rows.
REQ-008 Colour rules:
- Rows above the wall SHALL use CEIL_COLOR.
- Rows below the wall SHALL use FLOOR_COLOR.
- Wall rows with codes 3..5 SHALL use tex_pixel_in.
- Wall rows with any other nonzero code SHALL use FLAT_COLOR, written in ROW without a request.
REQ-009 Rows SHALL be processed 0..SCREEN_HEIGHT-1 in order, exactly one fb_we_out pulse per row.
REQ-010 fb_addr_out SHALL equal row*SCREEN_WIDTH+column, computed at 16-bit width with no overflow for 320x180.
REQ-011 Non-wall and flat rows SHALL be written on consecutive cycles, with row 0 written on the second cycle after accept.
REQ-012 tex_req_out SHALL be high for exactly one cycle per textured row, so it is always low for at least one cycle between requests.
REQ-013 wallX_out, lineheight_out, drawstart_out (unclamped), texture_out and vcount_ray_out SHALL stay stable from the REQ cycle through tex_valid_in.
REQ-014 A textured pixel SHALL be written on the cycle after tex_valid_in, using the texel sampled on the valid cycle.
REQ-015 tex_valid_in outside WAIT SHALL be ignored.
REQ-016 column_done_out SHALL pulse for one cycle in DONE.

Reset
REQ-017 Asserting rst_in at any time SHALL force IDLE immediately and discard the in-flight column.
REQ-018 During reset, and at its release, all outputs SHALL be 0 except dda_ready_out, which SHALL be 1.
REQ-019 After reset there SHALL be no further writes or requests until a new accept.

Configuration
REQ-020 With SIDE_SHADE_EN defined, wall pixels (textured and flat) SHALL be written as {r>>1, g>>1, b>>1} (RGB565 fields) when the latched side_in is 1.
REQ-021 With SIDE_SHADE_EN undefined, side_in SHALL be ignored and wall pixels SHALL be written unmodified.

Structure
REQ-022 SCREEN_WIDTH/HEIGHT defaults, the RGB565 pixel typedef, the state enum and the textured-code range 3..5 SHALL live in package raycast_pkg.
REQ-023 One sub-module, rgb565_shade, SHALL be used: combinational, halving each field.

Verification
REQ-024 Directed scenarios the bench SHALL cover:
- Column 10, drawstart 60, drawend 119, texture 3, bench returns tex_valid_in 3 cycles after each request with texel=row -> 60 ceiling, 60 textured (data=row), 60 floor writes; addresses 10, 330, ..., 57290; 60 request pulses.
- texture 0 -> 180 writes on consecutive cycles with no requests, column_done_out 1 cycle after row 179.
- drawstart -20, drawend 250, texture 1 -> all 180 rows FLAT_COLOR.
- drawend 40 < drawstart 50 -> rows 0..89 ceiling, rows 90..179 floor.
- rst_in asserted in WAIT at row 75 -> no further fb_we_out or tex_req_out; dda_ready_out=1; next column processes fully.
- SIDE_SHADE_EN defined, side 1, texel 16'hFFFF -> written 16'h7BEF; undefined -> 16'hFFFF.

Source files
------------

// File: rtl/raycast_pkg.sv
// Shared raycaster definitions: screen geometry defaults, RGB565 pixel type,
// column sequencer states and the textured map-code range.
package raycast_pkg;

    localparam int SCREEN_WIDTH_DEF  = 320;
    localparam int SCREEN_HEIGHT_DEF = 180;

    localparam logic [3:0] TEX_CODE_MIN = 4'd3;
    localparam logic [3:0] TEX_CODE_MAX = 4'd5;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic logic is_textured(input logic [3:0] code);
        return (code >= TEX_CODE_MIN) && (code <= TEX_CODE_MAX);
    endfunction

    // Signed ray row limit clamped onto the visible screen rows.
    function automatic logic [7:0] clamp_row(input logic signed [9:0] v, input int height);
        if (v < 10'sd0) begin
            return 8'd0;
        end
        if (int'(v) > height - 1) begin
            return 8'(height - 1);
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/rgb565_shade.sv
// Halves each RGB565 colour field; used to darken walls hit on the shaded side.
module rgb565_shade
    import raycast_pkg::*;
(
    input  rgb565_t pixel,
    output rgb565_t shaded
);

    always_comb begin
        shaded   = pixel;
        shaded.r = pixel.r >> 1;
        shaded.g = pixel.g >> 1;
        shaded.b = pixel.b >> 1;
    end

endmodule

// File: rtl/tex_column_seq.sv
// Column sequencer: walks one screen column top to bottom, emitting ceiling,
// wall (flat or texture-fetched) and floor pixels. Define SIDE_SHADE_EN to darken side-hit walls.
module tex_column_seq
    import raycast_pkg::*;
#(
    parameter int          SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int          SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter logic [15:0] CEIL_COLOR    = 16'h39E7,
    parameter logic [15:0] FLOOR_COLOR   = 16'h7BEF,
    parameter logic [15:0] FLAT_COLOR    = 16'hF800
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        dda_valid_in,
    output logic        dda_ready_out,
    input  logic [8:0]  hcount_ray_in,
    input  logic [7:0]  lineheight_in,
    input  logic [9:0]  drawstart_in,
    input  logic [9:0]  drawend_in,
    input  logic [15:0] wallX_in,
    input  logic [3:0]  texture_in,
    input  logic        side_in,
    output logic        tex_req_out,
    output logic [15:0] wallX_out,
    output logic [7:0]  lineheight_out,
    output logic [9:0]  drawstart_out,
    output logic [3:0]  texture_out,
    output logic [7:0]  vcount_ray_out,
    input  logic [15:0] tex_pixel_in,
    input  logic        tex_valid_in,
    output logic        fb_we_out,
    output logic [15:0] fb_addr_out,
    output logic [15:0] fb_data_out,
    output logic        column_done_out
);

`ifdef SIDE_SHADE_EN
    localparam bit SHADE_EN = 1'b1;
`else
    localparam bit SHADE_EN = 1'b0;
`endif

    state_t      state;
    logic [8:0]  column;
    logic [7:0]  ds_clamp;
    logic [7:0]  de_clamp;
    logic        wall_en;
    logic        side;
    logic [15:0] row_base;

    logic        in_wall;
    logic        textured;
    logic        last_row;
    logic [15:0] bg_color;
    logic [15:0] pixel_addr;
    rgb565_t     shade_src;
    rgb565_t     shade_out;
    logic [15:0] wall_color;
    logic [7:0]  ds_next;
    logic [7:0]  de_next;

    assign ds_next    = clamp_row($signed(drawstart_in), SCREEN_HEIGHT);
    assign de_next    = clamp_row($signed(drawend_in), SCREEN_HEIGHT);
    assign in_wall    = wall_en && (vcount_ray_out >= ds_clamp) && (vcount_ray_out <= de_clamp);
    assign textured   = is_textured(texture_out);
    assign last_row   = (vcount_ray_out == 8'(SCREEN_HEIGHT - 1));
    assign pixel_addr = row_base + 16'(column);

    // A column without wall rows splits the screen evenly between ceiling and floor.
    always_comb begin
        bg_color = FLOOR_COLOR;
        if (wall_en) begin
            if (vcount_ray_out < ds_clamp) begin
                bg_color = CEIL_COLOR;
            end
        end else if (vcount_ray_out < 8'(SCREEN_HEIGHT / 2)) begin
            bg_color = CEIL_COLOR;
        end
    end

    assign shade_src = (state == ST_WAIT) ? tex_pixel_in : FLAT_COLOR;

    rgb565_shade u_shade (
        .pixel  (shade_src),
        .shaded (shade_out)
    );

    assign wall_color = (SHADE_EN && side) ? shade_out : shade_src;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= ST_IDLE;
            dda_ready_out   <= 1'b1;
            tex_req_out     <= 1'b0;
            fb_we_out       <= 1'b0;
            fb_addr_out     <= '0;
            fb_data_out     <= '0;
            column_done_out <= 1'b0;
            wallX_out       <= '0;
            lineheight_out  <= '0;
            drawstart_out   <= '0;
            texture_out     <= '0;
            vcount_ray_out  <= '0;
            column          <= '0;
            ds_clamp        <= '0;
            de_clamp        <= '0;
            wall_en         <= 1'b0;
            side            <= 1'b0;
            row_base        <= '0;
        end else begin
            tex_req_out     <= 1'b0;
            fb_we_out       <= 1'b0;
            column_done_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dda_valid_in) begin
                        column         <= hcount_ray_in;
                        lineheight_out <= lineheight_in;
                        drawstart_out  <= drawstart_in;
                        wallX_out      <= wallX_in;
                        texture_out    <= texture_in;
                        side           <= side_in;
                        ds_clamp       <= ds_next;
                        de_clamp       <= de_next;
                        wall_en        <= (texture_in != 4'd0) && (de_next >= ds_next);
                        vcount_ray_out <= '0;
                        row_base       <= '0;
                        dda_ready_out  <= 1'b0;
                        state          <= ST_ROW;
                    end
                end
                ST_ROW: begin
                    if (in_wall && textured) begin
                        tex_req_out <= 1'b1;
                        state       <= ST_REQ;
                    end else begin
                        fb_we_out   <= 1'b1;
                        fb_addr_out <= pixel_addr;
                        fb_data_out <= in_wall ? wall_color : bg_color;
                        if (last_row) begin
                            state <= ST_DONE;
                        end else begin
                            vcount_ray_out <= vcount_ray_out + 8'd1;
                            row_base       <= row_base + 16'(SCREEN_WIDTH);
                        end
                    end
                end
                ST_REQ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tex_valid_in) begin
                        fb_we_out   <= 1'b1;
                        fb_addr_out <= pixel_addr;
                        fb_data_out <= wall_color;
                        if (last_row) begin
                            state <= ST_DONE;
                        end else begin
                            vcount_ray_out <= vcount_ray_out + 8'd1;
                            row_base       <= row_base + 16'(SCREEN_WIDTH);
                            state          <= ST_ROW;
                        end
                    end
                end
                ST_DONE: begin
                    column_done_out <= 1'b1;
                    dda_ready_out   <= 1'b1;
                    state           <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tex_column_seq.sv
// Self-checking bench for tex_column_seq: directed and random columns against a
// behavioural per-row colour model. Honours SIDE_SHADE_EN like the design.
module tb_tex_column_seq;

    localparam int          W     = 320;
    localparam int          H     = 180;
    localparam logic [15:0] CEIL  = 16'h39E7;
    localparam logic [15:0] FLOOR = 16'h7BEF;
    localparam logic [15:0] FLAT  = 16'hF800;
`ifdef SIDE_SHADE_EN
    localparam bit SHADE = 1'b1;
`else
    localparam bit SHADE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        dda_valid_in = 1'b0;
    logic        dda_ready_out;
    logic [8:0]  hcount_ray_in = '0;
    logic [7:0]  lineheight_in = '0;
    logic [9:0]  drawstart_in = '0;
    logic [9:0]  drawend_in = '0;
    logic [15:0] wallX_in = '0;
    logic [3:0]  texture_in = '0;
    logic        side_in = 1'b0;
    logic        tex_req_out;
    logic [15:0] wallX_out;
    logic [7:0]  lineheight_out;
    logic [9:0]  drawstart_out;
    logic [3:0]  texture_out;
    logic [7:0]  vcount_ray_out;
    logic [15:0] tex_pixel_in = '0;
    logic        tex_valid_in = 1'b0;
    logic        fb_we_out;
    logic [15:0] fb_addr_out;
    logic [15:0] fb_data_out;
    logic        column_done_out;

    always #5 clk = ~clk;

    tex_column_seq dut (
        .pixel_clk_in    (clk),
        .rst_in          (rst_in),
        .dda_valid_in    (dda_valid_in),
        .dda_ready_out   (dda_ready_out),
        .hcount_ray_in   (hcount_ray_in),
        .lineheight_in   (lineheight_in),
        .drawstart_in    (drawstart_in),
        .drawend_in      (drawend_in),
        .wallX_in        (wallX_in),
        .texture_in      (texture_in),
        .side_in         (side_in),
        .tex_req_out     (tex_req_out),
        .wallX_out       (wallX_out),
        .lineheight_out  (lineheight_out),
        .drawstart_out   (drawstart_out),
        .texture_out     (texture_out),
        .vcount_ray_out  (vcount_ray_out),
        .tex_pixel_in    (tex_pixel_in),
        .tex_valid_in    (tex_valid_in),
        .fb_we_out       (fb_we_out),
        .fb_addr_out     (fb_addr_out),
        .fb_data_out     (fb_data_out),
        .column_done_out (column_done_out)
    );

    int checks = 0;
    int errors = 0;

    // Results of the most recent column run.
    int          n_wr;
    int          n_req;
    int          done_cyc;
    bit          timed_out;
    bit          aborted;
    logic [15:0] w_addr [0:199];
    logic [15:0] w_data [0:199];
    int          w_cyc [0:199];
    logic [15:0] texel_for_row [0:H-1];
    int          valid_cyc_row [0:H-1];

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > H - 1) return H - 1;
        return v;
    endfunction

    function automatic logic [15:0] shade_px(input logic [15:0] px);
        int r, g, b;
        r = int'(px[15:11]) / 2;
        g = int'(px[10:5]) / 2;
        b = int'(px[4:0]) / 2;
        return 16'(r * 2048 + g * 32 + b);
    endfunction

    // Expected colour of one row from the screen rules.
    function automatic logic [15:0] model_px(input int row, input int ds, input int de,
                                             input int tex, input bit sd, input logic [15:0] texel);
        int dsc, dec;
        logic [15:0] px;
        dsc = clampi(ds);
        dec = clampi(de);
        if (tex == 0 || dec < dsc) return (row < H / 2) ? CEIL : FLOOR;
        if (row < dsc) return CEIL;
        if (row > dec) return FLOOR;
        px = (tex >= 3 && tex <= 5) ? texel : FLAT;
        if (SHADE && sd) px = shade_px(px);
        return px;
    endfunction

    function automatic int model_reqs(input int ds, input int de, input int tex);
        int dsc, dec;
        dsc = clampi(ds);
        dec = clampi(de);
        if (tex < 3 || tex > 5 || dec < dsc) return 0;
        return dec - dsc + 1;
    endfunction

    // Drives one descriptor and services texture requests; cycles count from the drive negedge.
    task automatic run_column(input int col, input int ds, input int de, input int lh, input int wx,
                              input int tex, input bit sd, input int texel_mode, input int abort_row);
        int c, valid_at, req_row;
        logic [15:0] pend_texel;
        n_wr = 0; n_req = 0; done_cyc = -1; timed_out = 0; aborted = 0;
        valid_at = -1; req_row = 0; pend_texel = '0;
        c = 0;
        while (dda_ready_out !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (dda_ready_out !== 1'b1) begin
            checks++; errors++; timed_out = 1;
            $display("FAIL ready_wait got %b want 1", dda_ready_out);
            return;
        end
        hcount_ray_in = 9'(col); drawstart_in = 10'(ds); drawend_in = 10'(de);
        lineheight_in = 8'(lh); wallX_in = 16'(wx); texture_in = 4'(tex); side_in = sd;
        dda_valid_in = 1'b1;
        c = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                dda_valid_in = 1'b0;
                checks++;
                if (dda_ready_out !== 1'b0) begin
                    errors++;
                    $display("FAIL accept_ready got %b want 0", dda_ready_out);
                end
            end
            if (tex_valid_in) tex_valid_in = 1'b0;
            tex_pixel_in = 16'($urandom);
            if (fb_we_out === 1'b1 && n_wr < 200) begin
                w_addr[n_wr] = fb_addr_out;
                w_data[n_wr] = fb_data_out;
                w_cyc[n_wr]  = c;
                n_wr++;
            end
            if (valid_at == c) begin
                checks++;
                if ({vcount_ray_out, wallX_out, lineheight_out, drawstart_out, texture_out} !==
                    {8'(req_row), 16'(wx), 8'(lh), 10'(ds), 4'(tex)}) begin
                    errors++;
                    $display("FAIL operands_stable got %h want %h",
                             {vcount_ray_out, wallX_out, lineheight_out, drawstart_out, texture_out},
                             {8'(req_row), 16'(wx), 8'(lh), 10'(ds), 4'(tex)});
                end
                tex_valid_in = 1'b1;
                tex_pixel_in = pend_texel;
                if (req_row < H) valid_cyc_row[req_row] = c;
            end
            if (tex_req_out === 1'b1) begin
                n_req++;
                req_row = int'(vcount_ray_out);
                if (req_row == abort_row) begin
                    aborted = 1;
                    return;
                end
                case (texel_mode)
                    0:       pend_texel = 16'(req_row);
                    1:       pend_texel = 16'($urandom);
                    default: pend_texel = 16'hFFFF;
                endcase
                if (req_row < H) texel_for_row[req_row] = pend_texel;
                valid_at = c + 2;
            end
            if (column_done_out === 1'b1) begin
                done_cyc = c;
                return;
            end
        end
        timed_out = 1; checks++; errors++;
        $display("FAIL column_timeout got %0d writes want column_done", n_wr);
    endtask

    task automatic test_reset();
        logic [81:0] got;
        rst_in = 1'b1;
        repeat (3) @(negedge clk);
        got = {dda_ready_out, tex_req_out, fb_we_out, column_done_out, fb_addr_out, fb_data_out,
               vcount_ray_out, wallX_out, lineheight_out, drawstart_out, texture_out};
        checks++;
        if (got !== {1'b1, 81'b0}) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", got, {1'b1, 81'b0});
        end
        rst_in = 1'b0;
        @(negedge clk);
        got = {dda_ready_out, tex_req_out, fb_we_out, column_done_out, fb_addr_out, fb_data_out,
               vcount_ray_out, wallX_out, lineheight_out, drawstart_out, texture_out};
        checks++;
        if (got !== {1'b1, 81'b0}) begin
            errors++;
            $display("FAIL reset_release got %h want %h", got, {1'b1, 81'b0});
        end
    endtask

    task automatic test_textured();
        logic [15:0] exp;
        run_column(10, 60, 119, 60, int'($urandom_range(0, 65535)), 3, 1'b0, 0, -1);
        checks++;
        if (n_wr != H) begin errors++; $display("FAIL tex_write_count got %0d want %0d", n_wr, H); end
        for (int r = 0; r < H && r < n_wr; r++) begin
            exp = (r < 60) ? CEIL : (r > 119) ? FLOOR : 16'(r);
            checks++;
            if (w_addr[r] !== 16'(r * W + 10) || w_data[r] !== exp) begin
                errors++;
                $display("FAIL tex_row %0d got addr %0d data %h want addr %0d data %h",
                         r, w_addr[r], w_data[r], r * W + 10, exp);
            end
            if (r >= 60 && r <= 119) begin
                checks++;
                if (w_cyc[r] != valid_cyc_row[r] + 1) begin
                    errors++;
                    $display("FAIL tex_latency row %0d got cycle %0d want %0d", r, w_cyc[r], valid_cyc_row[r] + 1);
                end
            end
        end
        checks++;
        if (n_req != 60) begin errors++; $display("FAIL tex_req_count got %0d want 60", n_req); end
        checks++;
        if (n_wr == H && done_cyc != w_cyc[H-1] + 1) begin
            errors++; $display("FAIL tex_done got %0d want %0d", done_cyc, w_cyc[H-1] + 1);
        end
    endtask

    // Columns with no textured rows: exact colours and back-to-back write timing.
    task automatic test_no_fetch(input string name, input int col, input int ds, input int de, input int tex);
        logic [15:0] exp;
        run_column(col, ds, de, 33, 16'h1234, tex, 1'b0, 1, -1);
        checks++;
        if (n_wr != H || n_req != 0) begin
            errors++; $display("FAIL %s_counts got %0d writes %0d reqs want %0d writes 0 reqs", name, n_wr, n_req, H);
        end
        for (int r = 0; r < H && r < n_wr; r++) begin
            exp = model_px(r, ds, de, tex, 1'b0, 16'h0000);
            checks++;
            if (w_addr[r] !== 16'(r * W + col) || w_data[r] !== exp || w_cyc[r] != r + 2) begin
                errors++;
                $display("FAIL %s_row %0d got addr %0d data %h cyc %0d want addr %0d data %h cyc %0d",
                         name, r, w_addr[r], w_data[r], w_cyc[r], r * W + col, exp, r + 2);
            end
        end
        checks++;
        if (done_cyc != H + 2) begin errors++; $display("FAIL %s_done got %0d want %0d", name, done_cyc, H + 2); end
    endtask

    task automatic test_reset_in_wait();
        int extra;
        logic [15:0] exp;
        run_column(20, 60, 119, 60, 16'hBEEF, 4, 1'b0, 1, 75);
        checks++;
        if (!aborted) begin errors++; $display("FAIL rst_wait_reach got %0d want 1", aborted); end
        @(negedge clk);
        rst_in = 1'b1;
        #1;
        checks++;
        if ({dda_ready_out, fb_we_out, tex_req_out, vcount_ray_out} !== {3'b100, 8'd0}) begin
            errors++;
            $display("FAIL rst_async got %h want %h", {dda_ready_out, fb_we_out, tex_req_out, vcount_ray_out}, {3'b100, 8'd0});
        end
        @(negedge clk);
        rst_in = 1'b0;
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            tex_valid_in = k[0];
            tex_pixel_in = 16'($urandom);
            @(negedge clk);
            if (fb_we_out !== 1'b0 || tex_req_out !== 1'b0 || dda_ready_out !== 1'b1) extra++;
        end
        tex_valid_in = 1'b0;
        checks++;
        if (extra != 0) begin errors++; $display("FAIL rst_quiet got %0d bad cycles want 0", extra); end
        run_column(21, 100, 140, 41, 16'h0F0F, 5, 1'b0, 1, -1);
        checks++;
        if (n_wr != H || n_req != 41) begin
            errors++; $display("FAIL rst_next_counts got %0d writes %0d reqs want %0d writes 41 reqs", n_wr, n_req, H);
        end
        for (int r = 0; r < H && r < n_wr; r++) begin
            exp = model_px(r, 100, 140, 5, 1'b0, texel_for_row[r]);
            checks++;
            if (w_addr[r] !== 16'(r * W + 21) || w_data[r] !== exp) begin
                errors++;
                $display("FAIL rst_next_row %0d got addr %0d data %h want addr %0d data %h", r, w_addr[r], w_data[r], r * W + 21, exp);
            end
        end
    endtask

    task automatic test_shade();
        logic [15:0] want;
        want = SHADE ? 16'h7BEF : 16'hFFFF;
        run_column(300, 80, 99, 20, 16'h0001, 3, 1'b1, 2, -1);
        checks++;
        if (n_wr != H) begin errors++; $display("FAIL shade_count got %0d want %0d", n_wr, H); end
        for (int r = 80; r <= 99 && r < n_wr; r++) begin
            checks++;
            if (w_data[r] !== want) begin
                errors++; $display("FAIL shade_tex row %0d got %h want %h", r, w_data[r], want);
            end
        end
        want = SHADE ? 16'h7800 : 16'hF800;
        run_column(301, 10, 20, 11, 16'h0002, 7, 1'b1, 2, -1);
        checks++;
        if (n_wr != H || w_data[15] !== want) begin
            errors++; $display("FAIL shade_flat got %0d writes data %h want %0d writes data %h", n_wr, w_data[15], H, want);
        end
    endtask

    task automatic test_back_to_back();
        int col, ds, de, tex, wx, lh, bad;
        bit sd;
        logic [15:0] exp;
        for (int t = 0; t < 10; t++) begin
            col = int'($urandom_range(0, W - 1));
            ds  = int'($urandom_range(0, 400)) - 100;
            de  = int'($urandom_range(0, 400)) - 100;
            tex = int'($urandom_range(0, 7));
            sd  = 1'($urandom);
            wx  = int'($urandom_range(0, 65535));
            lh  = int'($urandom_range(0, 255));
            run_column(col, ds, de, lh, wx, tex, sd, 1, -1);
            bad = 0;
            for (int r = 0; r < H && r < n_wr; r++) begin
                exp = model_px(r, ds, de, tex, sd, texel_for_row[r]);
                checks++;
                if (w_addr[r] !== 16'(r * W + col) || w_data[r] !== exp) begin
                    errors++; bad++;
                    if (bad < 4)
                        $display("FAIL rand%0d_row %0d got addr %0d data %h want addr %0d data %h",
                                 t, r, w_addr[r], w_data[r], r * W + col, exp);
                end
            end
            checks++;
            if (n_wr != H || n_req != model_reqs(ds, de, tex) || done_cyc != w_cyc[H-1] + 1) begin
                errors++;
                $display("FAIL rand%0d_summary got %0d writes %0d reqs done %0d want %0d writes %0d reqs done %0d",
                         t, n_wr, n_req, done_cyc, H, model_reqs(ds, de, tex), w_cyc[H-1] + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_textured();
        test_no_fetch("tex0", 5, 30, 150, 0);
        test_no_fetch("flat_clamp", 319, -20, 250, 1);
        test_no_fetch("inverted", 0, 50, 40, 3);
        test_reset_in_wait();
        test_shade();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
